// File: rtl/branch_predict_unit.sv
// Bimodal (2-bit saturating) branch predictor plus branch resolution for the PC mux.
// Defining BRANCH_STATS_EN enables the branch/mispredict statistics counters.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [2:0]       res_mode,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  res_alu_result,
  input  logic             res_pred_taken,
  output logic [1:0]       PCSrcs,
  output logic             flush,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredict,
  output logic             fsm_state
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  // fetch_valid and res_valid are single-cycle request strobes, accepted only
  // while ready is high; there is no backpressure and requests in INIT are dropped.
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] ptr;
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] fetch_idx, res_idx;
  logic             run;
  logic             is_branch, actual, mispredict, flush_next;
  logic [1:0]       src_next, cnt_cur, cnt_next;
  logic             unused_pc_bits;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign res_idx   = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                            res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  assign run       = (state == S_RUN);
  assign ready     = run;
  assign fsm_state = run;

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (ptr == IDX_W'(BHT_DEPTH - 1)) next_state = S_RUN;
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                ptr <= '0;
    else if (state == S_INIT) ptr <= ptr + IDX_W'(1);
  end

  // Resolve decode: jumps always redirect, branches redirect only on a mispredict.
  always_comb begin
    is_branch  = 1'b0;
    actual     = 1'b0;
    src_next   = 2'b11;
    flush_next = 1'b0;
    if (run && res_valid) begin
      case (res_mode)
        3'b000: begin src_next = 2'b00; flush_next = 1'b1; end
        3'b001: begin src_next = 2'b01; flush_next = 1'b1; end
        3'b010: begin is_branch = 1'b1; actual = (res_alu_result == '0); end
        3'b011: begin is_branch = 1'b1; actual = (res_alu_result != '0); end
        default: ;
      endcase
    end
    mispredict = is_branch && (actual != res_pred_taken);
    if (mispredict) begin
      flush_next = 1'b1;
      src_next   = actual ? 2'b10 : 2'b11;
    end
  end

  always_comb begin
    cnt_cur  = bht[res_idx];
    cnt_next = cnt_cur;
    if (actual) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
    end else if (cnt_cur != 2'b00) begin
      cnt_next = cnt_cur - 2'd1;
    end
  end

  // The table has no reset of its own; INIT sweeps every entry to weak not-taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) bht[ptr] <= 2'b01;
      else if (is_branch)  bht[res_idx] <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      PCSrcs     <= 2'b11;
      flush      <= 1'b0;
    end else begin
      pred_valid <= run && fetch_valid;
      if (run && fetch_valid) pred_taken <= bht[fetch_idx][1];
      PCSrcs     <= src_next;
      flush      <= flush_next;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (is_branch && (stat_branches != '1))
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && (stat_mispredict != '1))
        stat_mispredict <= stat_mispredict + CNT_W'(1);
    end
  end
`else
  assign stat_branches   = '0;
  assign stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table, hand-written reset/init
// sequences, and randomized traffic checked against a behavioural model.
module tb_branch_predict_unit;
  localparam int XLEN      = 32;
  localparam int BHT_DEPTH = 64;
  localparam int CNT_W     = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             ready;
  logic             fetch_valid;
  logic [XLEN-1:0]  fetch_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic [2:0]       res_mode;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  res_alu_result;
  logic             res_pred_taken;
  logic [1:0]       PCSrcs;
  logic             flush;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredict;
  logic             fsm_state;

  branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_mode(res_mode), .res_pc(res_pc),
    .res_alu_result(res_alu_result), .res_pred_taken(res_pred_taken),
    .PCSrcs(PCSrcs), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredict(stat_mispredict),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int bht_m [BHT_DEPTH];
  int init_left;
  logic exp_pt;
  logic [CNT_W-1:0] exp_br, exp_mis;
  logic [4:0] exp_q[$];  // {pred_valid, pred_taken, PCSrcs, flush}

  typedef struct {
    logic            fv;
    logic [XLEN-1:0] fpc;
    logic            rv;
    logic [2:0]      mode;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] alu;
    logic            rpt;
    logic            e_pv;
    logic            e_pt;
    logic [1:0]      e_src;
    logic            e_fl;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  task automatic drive_idle();
    fetch_valid = 0; fetch_pc = '0; res_valid = 0; res_mode = 3'b100;
    res_pc = '0; res_alu_result = '0; res_pred_taken = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    init_left = BHT_DEPTH;
    exp_pt = 1'b0; exp_br = '0; exp_mis = '0;
    chk("rst_ready", ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pcsrcs", PCSrcs, 2'b11);
    chk("rst_flush", flush, 0);
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mis", stat_mispredict, 0);
  endtask

  task automatic cycle(input logic fv, input logic [XLEN-1:0] fpc, input logic rv,
                       input logic [2:0] mode, input logic [XLEN-1:0] rpc,
                       input logic [XLEN-1:0] alu, input logic rpt);
    logic pv, fl, act_t, run;
    logic [1:0] src;
    logic [4:0] e;
    int i;
    fetch_valid = fv; fetch_pc = fpc; res_valid = rv; res_mode = mode;
    res_pc = rpc; res_alu_result = alu; res_pred_taken = rpt;
    run = (init_left == 0);
    pv = 0; src = 2'b11; fl = 0;
    if (run && fv) begin
      pv = 1;
      exp_pt = (bht_m[idx_of(fpc)] >= 2);
    end
    if (run && rv) begin
      if (mode == 3'd0) begin src = 2'b00; fl = 1; end
      else if (mode == 3'd1) begin src = 2'b01; fl = 1; end
      else if (mode == 3'd2 || mode == 3'd3) begin
        act_t = (mode == 3'd2) ? (alu == 0) : (alu != 0);
        if (act_t != rpt) begin
          fl = 1;
          src = act_t ? 2'b10 : 2'b11;
          if (exp_mis != '1) exp_mis++;
        end
        if (exp_br != '1) exp_br++;
        i = idx_of(rpc);
        bht_m[i] = act_t ? ((bht_m[i] == 3) ? 3 : bht_m[i] + 1)
                         : ((bht_m[i] == 0) ? 0 : bht_m[i] - 1);
      end
    end
    if (!run) init_left--;
    exp_q.push_back({pv, exp_pt, src, fl});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("pred_valid", pred_valid, e[4]);
    chk("pred_taken", pred_taken, e[3]);
    chk("pcsrcs", PCSrcs, e[2:1]);
    chk("flush", flush, e[0]);
    chk("ready", ready, init_left == 0);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, exp_br);
    chk("stat_mispredict", stat_mispredict, exp_mis);
`else
    chk("stat_branches", stat_branches, 0);
    chk("stat_mispredict", stat_mispredict, 0);
`endif
  endtask

  // INIT phase with requests deliberately presented; they must be ignored.
  task automatic wait_init();
    for (int k = 1; k < BHT_DEPTH; k++) begin
      cycle(1'b1, 32'h40, 1'b1, 3'd0, 32'h40, '0, 1'b0);
      chk("init_no_flush", flush, 0);
    end
    chk("ready_before_last", ready, 0);
    cycle(1'b0, '0, 1'b0, 3'd4, '0, '0, 1'b0);
    chk("ready_at_65", ready, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    do_reset();
    wait_init();

    //           fv fpc      rv mode rpc      alu rpt  pv pt src fl
    vecs.push_back('{1, 32'h000, 0, 3'd4, 32'h000, 0, 0, 1, 0, 2'b11, 0});
    vecs.push_back('{0, 32'h000, 1, 3'd2, 32'h040, 0, 0, 0, 0, 2'b10, 1});
    vecs.push_back('{0, 32'h000, 1, 3'd2, 32'h040, 0, 0, 0, 0, 2'b10, 1});
    vecs.push_back('{0, 32'h000, 1, 3'd2, 32'h040, 0, 0, 0, 0, 2'b10, 1});
    vecs.push_back('{1, 32'h040, 0, 3'd4, 32'h000, 0, 0, 1, 1, 2'b11, 0});
    vecs.push_back('{0, 32'h000, 1, 3'd3, 32'h080, 5, 1, 0, 1, 2'b11, 0});
    vecs.push_back('{0, 32'h000, 1, 3'd3, 32'h080, 0, 1, 0, 1, 2'b11, 1});
    vecs.push_back('{0, 32'h000, 1, 3'd0, 32'h200, 0, 0, 0, 1, 2'b00, 1});
    vecs.push_back('{0, 32'h000, 1, 3'd1, 32'h204, 0, 0, 0, 1, 2'b01, 1});
    vecs.push_back('{1, 32'h200, 0, 3'd4, 32'h000, 0, 0, 1, 0, 2'b11, 0});
    vecs.push_back('{1, 32'h204, 0, 3'd4, 32'h000, 0, 0, 1, 0, 2'b11, 0});
    vecs.push_back('{0, 32'h000, 1, 3'd4, 32'h040, 0, 0, 0, 0, 2'b11, 0});
    vecs.push_back('{0, 32'h000, 0, 3'd2, 32'h040, 0, 0, 0, 0, 2'b11, 0});
    vecs.push_back('{1, 32'h100, 1, 3'd2, 32'h100, 0, 0, 1, 0, 2'b10, 1});
    vecs.push_back('{1, 32'h103, 0, 3'd4, 32'h000, 0, 0, 1, 1, 2'b11, 0});
    vecs.push_back('{1, 32'h080, 0, 3'd4, 32'h000, 0, 0, 1, 0, 2'b11, 0});
    vecs.push_back('{1, 32'h040, 0, 3'd4, 32'h000, 0, 0, 1, 1, 2'b11, 0});

    foreach (vecs[n]) begin
      cycle(vecs[n].fv, vecs[n].fpc, vecs[n].rv, vecs[n].mode, vecs[n].rpc,
            vecs[n].alu, vecs[n].rpt);
      chk($sformatf("vec%0d_pred_valid", n), pred_valid, vecs[n].e_pv);
      chk($sformatf("vec%0d_pred_taken", n), pred_taken, vecs[n].e_pt);
      chk($sformatf("vec%0d_pcsrcs", n), PCSrcs, vecs[n].e_src);
      chk($sformatf("vec%0d_flush", n), flush, vecs[n].e_fl);
    end

    // Mid-run reset: 0x40 was trained to strongly taken, must come back weak not-taken.
    do_reset();
    wait_init();
    cycle(1'b1, 32'h40, 1'b0, 3'd4, '0, '0, 1'b0);
    chk("reinit_pred_taken_40", pred_taken, 0);

    // Reset in the middle of INIT restarts the full sweep.
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b0, 3'd4, '0, '0, 1'b0);
    do_reset();
    wait_init();

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      logic [XLEN-1:0] fpc, rpc, alu;
      fpc = ($urandom_range(0, 1) ? 32'h0 : 32'h100) + 32'($urandom_range(0, 15)) * 4
            + 32'($urandom_range(0, 3));
      rpc = ($urandom_range(0, 1) ? 32'h0 : 32'h100) + 32'($urandom_range(0, 15)) * 4;
      alu = ($urandom_range(0, 1) != 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(1'($urandom_range(0, 1)), fpc, 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), rpc, alu, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
